seg7_pattern_decoder: RTL and testbench

- Inverse of the team's nibble-to-7-segment logic: accepts 7-bit segment patterns over a valid/ready stream and recovers the 4-bit hex value.
- Flags any pattern that is not one of the 16 legal glyphs.
- Contains a 2-entry output buffer and a saturating error counter.
- Sits downstream of segment-pattern generators in the CGP benchmark harness, where it round-trip checks evolved encoder circuits.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_fifo2.sv | 53 +++++
 rtl/seg7_pattern_decoder.sv | 68 ++++++
 tb/tb_seg7_pattern_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and the segment glyph table for the 7-segment pattern decoder.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nib_t;

    typedef struct packed {
        logic err;
        nib_t nib;
    } entry_t;

    localparam seg_t SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Glyphs are unique, so at most one table entry can match; no match means illegal.
    function automatic entry_t seg_lookup(input seg_t seg);
        entry_t result;
        nib_t   idx;
        result.err = 1'b1;
        result.nib = '0;
        for (int i = 0; i < 16; i++) begin
            idx = nib_t'(i);
            if (seg == SEG_GLYPH[idx]) begin
                result.err = 1'b0;
                result.nib = idx;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_fifo2.sv
// Two-entry valid/ready buffer for decoded entries.
// in_ready depends only on occupancy, never combinationally on out_ready.
module seg7_fifo2
    import seg7_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  entry_t in_data,
    output logic   out_valid,
    input  logic   out_ready,
    output entry_t out_data
);

    entry_t     mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seg7_pattern_decoder.sv
// Recovers hex nibbles from 7-segment patterns, flagging illegal glyphs.
// Define SEG7_ERRCNT_EN to add the saturating err_count output.
module seg7_pattern_decoder
    import seg7_pkg::*;
#(
    parameter int ACTIVE_LOW = 0,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_seg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_nibble,
    output logic             out_err
`ifdef SEG7_ERRCNT_EN
    ,
    output logic [ERR_W-1:0] err_count
`endif
);

    seg_t   seg_high;
    entry_t decoded;
    entry_t head;

    // Common-anode sources drive segments low, so normalise before lookup.
    assign seg_high = (ACTIVE_LOW != 0) ? ~in_seg : in_seg;

    always_comb begin
        decoded = seg_lookup(seg_high);
    end

    seg7_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (decoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_nibble = head.nib;
    assign out_err    = head.err;

`ifdef SEG7_ERRCNT_EN
    logic accepted;

    assign accepted = in_valid && in_ready;

    // Counts at acceptance, so illegal patterns still queued are already included.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (accepted && decoded.err && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    logic cfg_unused;

    assign cfg_unused = ^ERR_W;
`endif

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Directed self-checking bench for seg7_pattern_decoder (default and ACTIVE_LOW
// instances; ERR_W=2 instance and counter checks when SEG7_ERRCNT_EN is defined).
module tb_seg7_pattern_decoder;

    logic       clk;
    logic       rst;

    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_seg;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_nibble;
    logic       out_err;

    logic       in_valid_al;
    logic       in_ready_al;
    logic [6:0] in_seg_al;
    logic       out_valid_al;
    logic [3:0] out_nibble_al;
    logic       out_err_al;

    int checks   = 0;
    int failures = 0;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

`ifdef SEG7_ERRCNT_EN
    logic [7:0] err_count;
    logic       in_valid_e2;
    logic       in_ready_e2;
    logic [6:0] in_seg_e2;
    logic       out_valid_e2;
    logic [3:0] out_nibble_e2;
    logic       out_err_e2;
    logic [1:0] err_count_e2;
    logic [6:0] bad_codes [5] = '{7'h00, 7'h7E, 7'h01, 7'h02, 7'h7B};
    logic [1:0] sat_expect [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif

    seg7_pattern_decoder #(.ACTIVE_LOW(0), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_seg     (in_seg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_nibble (out_nibble),
        .out_err    (out_err)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    seg7_pattern_decoder #(.ACTIVE_LOW(1), .ERR_W(8)) dut_al (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_al),
        .in_ready   (in_ready_al),
        .in_seg     (in_seg_al),
        .out_valid  (out_valid_al),
        .out_ready  (1'b1),
        .out_nibble (out_nibble_al),
        .out_err    (out_err_al)
`ifdef SEG7_ERRCNT_EN
        ,
        .err_count  ()
`endif
    );

`ifdef SEG7_ERRCNT_EN
    seg7_pattern_decoder #(.ACTIVE_LOW(0), .ERR_W(2)) dut_e2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid_e2),
        .in_ready   (in_ready_e2),
        .in_seg     (in_seg_e2),
        .out_valid  (out_valid_e2),
        .out_ready  (1'b1),
        .out_nibble (out_nibble_e2),
        .out_err    (out_err_e2),
        .err_count  (err_count_e2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_seg      = 7'h00;
        out_ready   = 1'b0;
        in_valid_al = 1'b0;
        in_seg_al   = 7'h00;
`ifdef SEG7_ERRCNT_EN
        in_valid_e2 = 1'b0;
        in_seg_e2   = 7'h00;
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_nibble", out_nibble, 0);
        check_output("rst_out_err", out_err, 0);
        check_output("rst_in_ready", in_ready, 1);
`ifdef SEG7_ERRCNT_EN
        check_output("rst_err_count", err_count, 0);
`endif
        tick();
        check_output("idle_out_valid", out_valid, 0);

        // Full glyph stream, out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_seg   = glyph[i];
            tick();
            check_output($sformatf("stream_valid_%0d", i), out_valid, 1);
            check_output($sformatf("stream_nibble_%0d", i), out_nibble, i);
            check_output($sformatf("stream_err_%0d", i), out_err, 0);
            check_output($sformatf("stream_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check_output("stream_drained", out_valid, 0);

        // Illegal codes then a legal zero
        in_valid = 1'b1;
        in_seg   = 7'h00;
        tick();
        check_output("ill00_valid", out_valid, 1);
        check_output("ill00_err", out_err, 1);
        check_output("ill00_nibble", out_nibble, 0);
        in_seg = 7'h7E;
        tick();
        check_output("ill7E_err", out_err, 1);
        check_output("ill7E_nibble", out_nibble, 0);
        in_seg = 7'h3F;
        tick();
        check_output("leg3F_err", out_err, 0);
        check_output("leg3F_nibble", out_nibble, 0);
        in_valid = 1'b0;
        in_seg   = 7'bx;
        tick();
        check_output("ill_drained", out_valid, 0);
        tick();
        check_output("x_idle_valid", out_valid, 0);
        check_output("x_idle_ready", in_ready, 1);
`ifdef SEG7_ERRCNT_EN
        check_output("err_count_two", err_count, 2);
`endif

        // Backpressure: two accepted, third stalls until after first pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_seg    = 7'h4F;
        tick();
        check_output("bp_first_nibble", out_nibble, 3);
        check_output("bp_first_ready", in_ready, 1);
        in_seg = 7'h66;
        tick();
        check_output("bp_full_ready", in_ready, 0);
        check_output("bp_full_nibble", out_nibble, 3);
        in_seg = 7'h6D;
        tick();
        check_output("bp_stall_ready", in_ready, 0);
        check_output("bp_stall_nibble", out_nibble, 3);
        tick();
        check_output("bp_hold_nibble", out_nibble, 3);
        check_output("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check_output("bp_pop1_nibble", out_nibble, 4);
        check_output("bp_pop1_ready", in_ready, 1);
        tick();
        check_output("bp_pop2_nibble", out_nibble, 5);
        check_output("bp_pop2_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check_output("bp_drained", out_valid, 0);

        // Count=1 with simultaneous push and pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_seg    = 7'h06;
        tick();
        check_output("c1_setup_nibble", out_nibble, 1);
        out_ready = 1'b1;
        in_seg = 7'h07;
        tick();
        check_output("c1_nib7", out_nibble, 7);
        check_output("c1_ready7", in_ready, 1);
        in_seg = 7'h7F;
        tick();
        check_output("c1_nib8", out_nibble, 8);
        check_output("c1_ready8", in_ready, 1);
        in_seg = 7'h6F;
        tick();
        check_output("c1_nib9", out_nibble, 9);
        in_seg = 7'h77;
        tick();
        check_output("c1_nibA", out_nibble, 10);
        check_output("c1_readyA", in_ready, 1);
        in_valid = 1'b0;
        tick();
        check_output("c1_drained", out_valid, 0);

        // Reset with two entries queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_seg    = 7'h5B;
        tick();
        in_seg = 7'h4F;
        tick();
        check_output("mid_full_ready", in_ready, 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check_output("mid_rst_valid", out_valid, 0);
        check_output("mid_rst_ready", in_ready, 1);
        check_output("mid_rst_nibble", out_nibble, 0);
`ifdef SEG7_ERRCNT_EN
        check_output("mid_rst_err_count", err_count, 0);
`endif
        out_ready = 1'b1;
        tick();
        check_output("mid_rst_no_emit", out_valid, 0);

        // Active-low instance
        in_valid_al = 1'b1;
        in_seg_al   = ~7'h3F;
        tick();
        check_output("al_valid", out_valid_al, 1);
        check_output("al_nibble", out_nibble_al, 0);
        check_output("al_err", out_err_al, 0);
        in_seg_al = 7'h3F;
        tick();
        check_output("al_raw_err", out_err_al, 1);
        in_seg_al = ~7'h71;
        tick();
        check_output("al_nibF", out_nibble_al, 15);
        in_valid_al = 1'b0;
        tick();

`ifdef SEG7_ERRCNT_EN
        // Narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            in_valid_e2 = 1'b1;
            in_seg_e2   = bad_codes[i];
            tick();
            check_output($sformatf("sat_%0d", i), err_count_e2, sat_expect[i]);
        end
        in_valid_e2 = 1'b0;
        tick();
        check_output("sat_hold", err_count_e2, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
